alu_seq: RTL and testbench

- Parametrised, registered successor to the team's 4-bit combinational ALU (alu4).
- Generalises the datapath to WIDTH bits and keeps its eight opcodes unchanged.
- Adds carry-chained arithmetic, shifts, compare, a persistent flag register and a multi-cycle shift-add multiplier behind a valid/ready handshake.
- Sits between the operand register file and the writeback stage of the team's small datapath.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_mul_seq.sv | 56 +++++
 rtl/alu_seq.sv | 124 ++++++++++++
 tb/tb_alu_seq.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode map, FSM states and flag-vector layout for alu_seq.
package alu_pkg;

    localparam logic [3:0] OP_NOTA  = 4'h0;
    localparam logic [3:0] OP_NOTB  = 4'h1;
    localparam logic [3:0] OP_AND   = 4'h2;
    localparam logic [3:0] OP_OR    = 4'h3;
    localparam logic [3:0] OP_XOR   = 4'h4;
    localparam logic [3:0] OP_XNOR  = 4'h5;
    localparam logic [3:0] OP_ADD   = 4'h6;
    localparam logic [3:0] OP_SUB   = 4'h7;
    localparam logic [3:0] OP_ADC   = 4'h8;
    localparam logic [3:0] OP_SBC   = 4'h9;
    localparam logic [3:0] OP_SHL   = 4'hA;
    localparam logic [3:0] OP_SHR   = 4'hB;
    localparam logic [3:0] OP_ASR   = 4'hC;
    localparam logic [3:0] OP_MUL   = 4'hD;
    localparam logic [3:0] OP_CMP   = 4'hE;
    localparam logic [3:0] OP_PASSA = 4'hF;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    // Flag vector is packed {c,n,z,v}.
    typedef logic [3:0] flags_t;
    localparam int FLAG_C = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, WIDTH cycles.
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] prod_lo,
    output logic             prod_hi_nz
);
    localparam int CW = $clog2(WIDTH) + 1;

    logic [2*WIDTH-1:0] mcand_q, acc_q, acc_next;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic               run_q;

    // The final partial product is folded in combinationally so the product
    // is available on the same edge as the last iteration.
    always_comb begin
        acc_next   = acc_q + (mplier_q[0] ? mcand_q : '0);
        done       = run_q && (cnt_q == CW'(1));
        prod_lo    = acc_next[WIDTH-1:0];
        prod_hi_nz = |acc_next[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b0;
        end else if (!run_q) begin
            if (start) begin
                mcand_q  <= {{WIDTH{1'b0}}, a};
                acc_q    <= '0;
                mplier_q <= b;
                cnt_q    <= CW'(WIDTH);
                run_q    <= 1'b1;
            end
        end else begin
            acc_q    <= acc_next;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) run_q <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Registered WIDTH-bit ALU with persistent flags and a multi-cycle multiplier.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic             c,
    output logic             n,
    output logic             z,
    output logic             v,
    output logic             busy
);
    localparam int SHW = $clog2(WIDTH);

    if (WIDTH < 4 || (WIDTH & (WIDTH - 1)) != 0) begin : g_bad_width
        $error("alu_seq: WIDTH must be a power of two and >= 4");
    end

    state_t           state_q;
    logic [WIDTH-1:0] result_q, res_d, bb;
    flags_t           flags_q, flags_d;
    logic             out_valid_q, cin, c_d, v_d, accept;
    logic [WIDTH:0]   sum, shl_full, shr_full, asr_full;
    logic [SHW-1:0]   sh;
    logic             mul_done, mul_hi_nz;
    logic [WIDTH-1:0] mul_lo;

    assign accept = in_valid && in_ready;

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk        (clk),
        .reset      (reset),
        .start      (accept && op == OP_MUL),
        .a          (a),
        .b          (b),
        .done       (mul_done),
        .prod_lo    (mul_lo),
        .prod_hi_nz (mul_hi_nz)
    );

    // One carry-chained adder serves ADD/SUB/ADC/SBC/CMP via operand inversion.
    always_comb begin
        bb  = (op == OP_SUB || op == OP_SBC || op == OP_CMP) ? ~b : b;
        case (op)
            OP_SUB, OP_CMP: cin = 1'b1;
            OP_ADC, OP_SBC: cin = flags_q[FLAG_C];
            default:        cin = 1'b0;
        endcase
        sum      = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, cin};
        sh       = b[SHW-1:0];
        shl_full = {1'b0, a} << sh;
        shr_full = {a, 1'b0} >> sh;
        asr_full = $signed({a, 1'b0}) >>> sh;
        res_d    = a;
        c_d      = 1'b0;
        v_d      = 1'b0;
        case (op)
            OP_NOTA: res_d = ~a;
            OP_NOTB: res_d = ~b;
            OP_AND:  res_d = a & b;
            OP_OR:   res_d = a | b;
            OP_XOR:  res_d = a ^ b;
            OP_XNOR: res_d = ~(a ^ b);
            OP_ADD, OP_SUB, OP_ADC, OP_SBC, OP_CMP: begin
                res_d = sum[WIDTH-1:0];
                c_d   = sum[WIDTH];
                v_d   = (a[WIDTH-1] == bb[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SHL: {c_d, res_d} = shl_full;
            OP_SHR: {res_d, c_d} = shr_full;
            OP_ASR: {res_d, c_d} = asr_full;
            default: res_d = a;
        endcase
        flags_d = {c_d, res_d[WIDTH-1], ~|res_d, v_d};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            result_q    <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: if (accept) begin
                    if (op == OP_MUL) begin
                        state_q <= S_MUL;
                    end else begin
                        if (op != OP_CMP) result_q <= res_d;
                        flags_q     <= flags_d;
                        out_valid_q <= 1'b1;
                    end
                end
                S_MUL: if (mul_done) begin
                    result_q    <= mul_lo;
                    flags_q     <= {mul_hi_nz, mul_lo[WIDTH-1], ~|mul_lo, 1'b0};
                    out_valid_q <= 1'b1;
                    state_q     <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_MUL);
    assign result    = result_q;
    assign out_valid = out_valid_q;
    assign c         = flags_q[FLAG_C];
    assign n         = flags_q[FLAG_N];
    assign z         = flags_q[FLAG_Z];
    assign v         = flags_q[FLAG_V];

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=4 and WIDTH=8 with hand-computed vectors.
module tb_alu_seq;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic       iv4 = 1'b0, rdy4, ov4, c4, n4, z4, v4, busy4;
    logic [3:0] a4 = '0, b4 = '0, op4 = '0, res4;
    logic       iv8 = 1'b0, rdy8, ov8, c8, n8, z8, v8, busy8;
    logic [7:0] a8 = '0, b8 = '0, res8;
    logic [3:0] op8 = '0;

    int errs = 0;
    int checks = 0;
    logic [10:0] got4, exp4;
    logic [14:0] got8, exp8;

    alu_seq #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(iv4), .in_ready(rdy4), .a(a4), .b(b4),
        .op(op4), .result(res4), .out_valid(ov4), .c(c4), .n(n4), .z(z4), .v(v4),
        .busy(busy4)
    );

    alu_seq #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(rdy8), .a(a8), .b(b8),
        .op(op8), .result(res8), .out_valid(ov8), .c(c8), .n(n8), .z(z8), .v(v8),
        .busy(busy8)
    );

    // Observation vectors: {out_valid, result, c, n, z, v, in_ready, busy}
    task automatic chk4(input string name, input logic [10:0] e);
        exp4 = e;
        got4 = {ov4, res4, c4, n4, z4, v4, rdy4, busy4};
        checks++;
        if (got4 !== exp4) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, got4, exp4);
        end
    endtask

    task automatic chk8(input string name, input logic [14:0] e);
        exp8 = e;
        got8 = {ov8, res8, c8, n8, z8, v8, rdy8, busy8};
        checks++;
        if (got8 !== exp8) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, got8, exp8);
        end
    endtask

    task automatic drv4(input logic vld, input logic [3:0] o, input logic [3:0] x, input logic [3:0] y);
        iv4 = vld; op4 = o; a4 = x; b4 = y;
    endtask

    task automatic drv8(input logic vld, input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
        iv8 = vld; op8 = o; a8 = x; b8 = y;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(negedge clk);
        chk4("reset4", {1'b0, 4'h0, 4'b0000, 1'b1, 1'b0});
        chk8("reset8", {1'b0, 8'h00, 4'b0000, 1'b1, 1'b0});
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_add4;
        drv4(1'b1, OP_ADD, 4'h8, 4'hD);
        chk4("add4_pre", {1'b0, 4'h0, 4'b0000, 1'b1, 1'b0});
        @(negedge clk);
        chk4("add4_8pD", {1'b1, 4'h5, 4'b1001, 1'b1, 1'b0});
        drv4(1'b1, OP_ADD, 4'hF, 4'hF);
        @(negedge clk);
        chk4("add4_FpF", {1'b1, 4'hE, 4'b1100, 1'b1, 1'b0});
        drv4(1'b0, OP_ADD, 4'h0, 4'h0);
        @(negedge clk);
        chk4("add4_idle", {1'b0, 4'hE, 4'b1100, 1'b1, 1'b0});
    endtask

    task automatic test_sub4;
        // 3 - (-7) = 10 does not fit a signed nibble, so v is set.
        drv4(1'b1, OP_SUB, 4'h3, 4'h9);
        @(negedge clk);
        chk4("sub4_3m9", {1'b1, 4'hA, 4'b0101, 1'b1, 1'b0});
        drv4(1'b1, OP_SUB, 4'hA, 4'hA);
        @(negedge clk);
        chk4("sub4_AmA", {1'b1, 4'h0, 4'b1010, 1'b1, 1'b0});
        drv4(1'b1, OP_CMP, 4'h7, 4'h2);
        @(negedge clk);
        chk4("cmp4_7v2", {1'b1, 4'h0, 4'b1000, 1'b1, 1'b0});
        drv4(1'b0, OP_ADD, 4'h0, 4'h0);
    endtask

    task automatic test_back_to_back8;
        drv8(1'b1, OP_ADD, 8'hFF, 8'h01);
        @(negedge clk);
        chk8("add8_FFp01", {1'b1, 8'h00, 4'b1010, 1'b1, 1'b0});
        drv8(1'b1, OP_ADC, 8'h00, 8'h00);
        @(negedge clk);
        chk8("adc8_c1", {1'b1, 8'h01, 4'b0000, 1'b1, 1'b0});
        drv8(1'b1, OP_SBC, 8'h05, 8'h03);
        @(negedge clk);
        chk8("sbc8_c0", {1'b1, 8'h01, 4'b1000, 1'b1, 1'b0});
    endtask

    task automatic test_shift8;
        drv8(1'b1, OP_SHL, 8'h81, 8'h01);
        @(negedge clk);
        chk8("shl8_81_1", {1'b1, 8'h02, 4'b1000, 1'b1, 1'b0});
        drv8(1'b1, OP_ASR, 8'h80, 8'h03);
        @(negedge clk);
        chk8("asr8_80_3", {1'b1, 8'hF0, 4'b0100, 1'b1, 1'b0});
        drv8(1'b1, OP_SHR, 8'h80, 8'h00);
        @(negedge clk);
        chk8("shr8_80_0", {1'b1, 8'h80, 4'b0100, 1'b1, 1'b0});
        drv8(1'b0, OP_ADD, 8'h00, 8'h00);
        @(negedge clk);
        chk8("shift8_idle", {1'b0, 8'h80, 4'b0100, 1'b1, 1'b0});
    endtask

    task automatic test_mul8;
        drv8(1'b1, OP_MUL, 8'h10, 8'h10);
        @(negedge clk);
        for (int k = 1; k <= 8; k++) begin
            // A stray request mid-run must be dropped, not queued.
            if (k == 4) drv8(1'b1, OP_ADD, 8'h01, 8'h01);
            else drv8(1'b0, OP_ADD, 8'h00, 8'h00);
            chk8($sformatf("mul8_busy_%0d", k), {1'b0, 8'h80, 4'b0100, 1'b0, 1'b1});
            @(negedge clk);
        end
        chk8("mul8_10x10", {1'b1, 8'h00, 4'b1010, 1'b1, 1'b0});
        drv8(1'b1, OP_MUL, 8'h0C, 8'h0B);
        @(negedge clk);
        drv8(1'b0, OP_ADD, 8'h00, 8'h00);
        for (int k = 1; k < 8; k++) @(negedge clk);
        chk8("mul8_last_busy", {1'b0, 8'h00, 4'b1010, 1'b0, 1'b1});
        @(negedge clk);
        chk8("mul8_0Cx0B", {1'b1, 8'h84, 4'b0100, 1'b1, 1'b0});
        @(negedge clk);
        chk8("mul8_after", {1'b0, 8'h84, 4'b0100, 1'b1, 1'b0});
    endtask

    task automatic test_mul_reset8;
        drv8(1'b1, OP_MUL, 8'h0C, 8'h0B);
        @(negedge clk);
        drv8(1'b0, OP_ADD, 8'h00, 8'h00);
        for (int k = 1; k < 4; k++) @(negedge clk);
        chk8("mulrst_busy", {1'b0, 8'h84, 4'b0100, 1'b0, 1'b1});
        reset = 1'b1;
        #1;
        chk8("mulrst_async", {1'b0, 8'h00, 4'b0000, 1'b1, 1'b0});
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 8; k++) @(negedge clk);
        chk8("mulrst_no_ov", {1'b0, 8'h00, 4'b0000, 1'b1, 1'b0});
        drv8(1'b1, OP_ADD, 8'h01, 8'h01);
        @(negedge clk);
        chk8("mulrst_add", {1'b1, 8'h02, 4'b0000, 1'b1, 1'b0});
        drv8(1'b0, OP_ADD, 8'h00, 8'h00);
    endtask

    initial begin
        test_reset();
        test_add4();
        test_sub4();
        test_back_to_back8();
        test_shift8();
        test_mul8();
        test_mul_reset8();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
